// File: rtl/multi_glitch_filter.sv
// multi_glitch_filter: per-channel synchroniser plus programmable-length stability filter.
// Optional glitch status ports enabled by MULTI_GLITCH_FILTER_STATUS_EN.
`timescale 1ns/1ps
module multi_glitch_filter #(
  parameter int                NUM_CH      = 4,
  parameter int                CNT_W       = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [NUM_CH-1:0] RST_VAL     = {NUM_CH{1'b0}}
) (
  input  logic              clk,
  input  logic              restn,
  input  logic [CNT_W-1:0]  filt_len,
  input  logic [NUM_CH-1:0] in,
  output logic [NUM_CH-1:0] out,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall
`ifdef MULTI_GLITCH_FILTER_STATUS_EN
  ,
  input  logic [NUM_CH-1:0] glitch_clr,
  output logic [NUM_CH-1:0] glitch_sticky
`endif
);

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
  logic [NUM_CH-1:0]                  s;
  logic [CNT_W-1:0]                   len_m1;
  logic [NUM_CH-1:0][CNT_W-1:0]       cnt_q;
  logic [NUM_CH-1:0][CNT_W-1:0]       cnt_d;
  logic [NUM_CH-1:0]                  out_d;
  logic [NUM_CH-1:0]                  rise_d;
  logic [NUM_CH-1:0]                  fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  // A zero length behaves as one; compare against length-1.
  assign len_m1 = (filt_len == '0) ? '0
                                   : filt_len - CNT_W'(1);

  // Synchroniser chain: the only logic that sees the raw inputs.
  always_ff @(posedge clk) begin
    if (!restn) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
    end
  end

  // Per-channel stability count; commit the new level at the limit.
  always_comb begin
    out_d  = out;
    cnt_d  = cnt_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      unique case (1'b1)
        (s[i] == out[i]): begin
          cnt_d[i] = '0;
        end
        ((s[i] != out[i]) && (cnt_q[i] >= len_m1)): begin
          out_d[i]  = s[i];
          cnt_d[i]  = '0;
          rise_d[i] = s[i];
          fall_d[i] = ~s[i];
        end
        default: begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      endcase
    end
  end

  // Filter state and edge pulses.
  always_ff @(posedge clk) begin
    if (!restn) begin
      cnt_q <= '0;
      out   <= RST_VAL;
      rise  <= '0;
      fall  <= '0;
    end else begin
      cnt_q <= cnt_d;
      out   <= out_d;
      rise  <= rise_d;
      fall  <= fall_d;
    end
  end

`ifdef MULTI_GLITCH_FILTER_STATUS_EN
  logic [NUM_CH-1:0] glitch;

  // A glitch is a return to the current level with a count in progress.
  always_comb begin
    glitch = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      glitch[i] = (s[i] == out[i]) && (cnt_q[i] != '0);
    end
  end

  // Sticky glitch flags; a new glitch beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!restn) begin
      glitch_sticky <= '0;
    end else begin
      glitch_sticky <= (glitch_sticky & ~glitch_clr) | glitch;
    end
  end
`endif

endmodule

// File: tb/tb_multi_glitch_filter.sv
// tb_multi_glitch_filter: directed scenarios with a cycle-stamped expectation queue.
// Status checks are compiled in only with MULTI_GLITCH_FILTER_STATUS_EN.
`timescale 1ns/1ps
module tb_multi_glitch_filter;

  logic       clk = 1'b0;
  logic       restn;
  logic [7:0] filt_len;
  logic [3:0] in;
  logic [3:0] out;
  logic [3:0] rise;
  logic [3:0] fall;
`ifdef MULTI_GLITCH_FILTER_STATUS_EN
  logic [3:0] glitch_clr;
  logic [3:0] glitch_sticky;
`endif

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [3:0] o;
    logic [3:0] r;
    logic [3:0] f;
    string      tag;
  } exp_t;

  exp_t sb[$];

  multi_glitch_filter #(
    .NUM_CH     (4),
    .CNT_W      (8),
    .SYNC_STAGES(2),
    .RST_VAL    (4'b0101)
  ) dut (
    .clk     (clk),
    .restn   (restn),
    .filt_len(filt_len),
    .in      (in),
    .out     (out),
    .rise    (rise),
    .fall    (fall)
`ifdef MULTI_GLITCH_FILTER_STATUS_EN
    ,
    .glitch_clr   (glitch_clr),
    .glitch_sticky(glitch_sticky)
`endif
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input int off,
                      input logic [3:0] o, input logic [3:0] r,
                      input logic [3:0] f);
    exp_t e;
    e.cyc = cyc + off;
    e.o   = o;
    e.r   = r;
    e.f   = f;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_quiet(input string tag, input int a,
                            input int b, input logic [3:0] o);
    for (int k = a; k <= b; k++) push(tag, k, o, 4'b0, 4'b0);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    checks++;
    assert ((rise & fall) === 4'b0000) else begin
      errors++;
      $error("FAIL excl @cyc %0d: rise&fall=%b want 0000",
             cyc, rise & fall);
    end
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      assert (e.cyc == cyc && out === e.o &&
              rise === e.r && fall === e.f) else begin
        errors++;
        $error("FAIL %s @cyc %0d: got out=%b rise=%b fall=%b want out=%b rise=%b fall=%b",
               e.tag, cyc, out, rise, fall, e.o, e.r, e.f);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

`ifdef MULTI_GLITCH_FILTER_STATUS_EN
  task automatic chk_sticky(input string tag, input logic [3:0] exp);
    checks++;
    assert (glitch_sticky === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: got sticky=%b want %b",
             tag, cyc, glitch_sticky, exp);
    end
  endtask
`endif

  initial begin
    restn    = 1'b0;
    in       = 4'b1010;
    filt_len = 8'd5;
`ifdef MULTI_GLITCH_FILTER_STATUS_EN
    glitch_clr = 4'b0;
`endif

    // reset held three cycles
    push_quiet("reset", 1, 3, 4'b0101);
    run(3);
`ifdef MULTI_GLITCH_FILTER_STATUS_EN
    chk_sticky("reset_sticky", 4'b0000);
`endif

    // release with in held: all channels toggle 7 clocks later
    restn = 1'b1;
    push_quiet("rel_hold", 1, 6, 4'b0101);
    push("rel_edge", 7, 4'b1010, 4'b1010, 4'b0101);
    push("rel_after", 8, 4'b1010, 4'b0, 4'b0);
    run(8);

    // latency, rising edge on channel 0
    in = 4'b1011;
    push_quiet("lat_wait", 1, 6, 4'b1010);
    push("lat_rise", 7, 4'b1011, 4'b0001, 4'b0);
    push("lat_after", 8, 4'b1011, 4'b0, 4'b0);
    run(8);

    // latency, falling edge on channel 0
    in = 4'b1010;
    push_quiet("latf_wait", 1, 6, 4'b1011);
    push("latf_fall", 7, 4'b1010, 4'b0, 4'b0001);
    push("latf_after", 8, 4'b1010, 4'b0, 4'b0);
    run(8);

    // 4-cycle glitch is rejected
    in = 4'b1011;
    push_quiet("glitch4", 1, 10, 4'b1010);
    run(4);
    in = 4'b1010;
    run(6);
`ifdef MULTI_GLITCH_FILTER_STATUS_EN
    chk_sticky("sticky_set", 4'b0001);
    run(2);
    chk_sticky("sticky_hold", 4'b0001);
    glitch_clr = 4'b0001;
    run(1);
    glitch_clr = 4'b0000;
    chk_sticky("sticky_clr", 4'b0000);
`endif

    // glitch with a clear in the same cycle
    in = 4'b1011;
    push_quiet("glitch_clr", 1, 10, 4'b1010);
    run(4);
    in = 4'b1010;
    run(2);
`ifdef MULTI_GLITCH_FILTER_STATUS_EN
    glitch_clr = 4'b0001;
`endif
    run(1);
`ifdef MULTI_GLITCH_FILTER_STATUS_EN
    glitch_clr = 4'b0000;
    chk_sticky("sticky_setwins", 4'b0001);
`endif
    run(3);

    // 5-cycle pulse passes and lasts 5 cycles
    in = 4'b1011;
    push_quiet("p5_wait", 1, 6, 4'b1010);
    push("p5_rise", 7, 4'b1011, 4'b0001, 4'b0);
    push_quiet("p5_high", 8, 11, 4'b1011);
    push("p5_fall", 12, 4'b1010, 4'b0, 4'b0001);
    push("p5_after", 13, 4'b1010, 4'b0, 4'b0);
    run(5);
    in = 4'b1010;
    run(8);

    // filt_len=0 behaves as 1: 3-clock latency
    filt_len = 8'd0;
    in = 4'b1011;
    push_quiet("l0_wait", 1, 2, 4'b1010);
    push("l0_rise", 3, 4'b1011, 4'b0001, 4'b0);
    push("l0_after", 4, 4'b1011, 4'b0, 4'b0);
    run(4);
    in = 4'b1010;
    push_quiet("l0f_wait", 1, 2, 4'b1011);
    push("l0_fall", 3, 4'b1010, 4'b0, 4'b0001);
    push("l0f_after", 4, 4'b1010, 4'b0, 4'b0);
    run(4);

    // filt_len=255 needs 255 stable cycles
    filt_len = 8'd255;
    in = 4'b1011;
    push("l255_start", 1, 4'b1010, 4'b0, 4'b0);
    push("l255_early", 256, 4'b1010, 4'b0, 4'b0);
    push("l255_rise", 257, 4'b1011, 4'b0001, 4'b0);
    push("l255_after", 258, 4'b1011, 4'b0, 4'b0);
    run(258);
    filt_len = 8'd5;
    in = 4'b1010;
    push_quiet("l255f_wait", 1, 6, 4'b1011);
    push("l255_fall", 7, 4'b1010, 4'b0, 4'b0001);
    push("l255f_after", 8, 4'b1010, 4'b0, 4'b0);
    run(8);

    // lower filt_len 200->3 at cnt=50
    filt_len = 8'd200;
    in = 4'b1011;
    push_quiet("mid_wait", 1, 52, 4'b1010);
    run(52);
    filt_len = 8'd3;
    push("mid_rise", 1, 4'b1011, 4'b0001, 4'b0);
    push("mid_after", 2, 4'b1011, 4'b0, 4'b0);
    run(2);
    in = 4'b1010;
    push_quiet("l3f_wait", 1, 4, 4'b1011);
    push("l3_fall", 5, 4'b1010, 4'b0, 4'b0001);
    push("l3f_after", 6, 4'b1010, 4'b0, 4'b0);
    run(6);

    // reset for one cycle at cnt=3, then full recount
    filt_len = 8'd5;
    in = 4'b1011;
    push_quiet("rmid_cnt", 1, 5, 4'b1010);
    run(5);
    restn = 1'b0;
    in = 4'b1010;
    push("rmid_reset", 1, 4'b0101, 4'b0, 4'b0);
    run(1);
`ifdef MULTI_GLITCH_FILTER_STATUS_EN
    chk_sticky("rmid_sticky", 4'b0000);
`endif
    restn = 1'b1;
    push_quiet("rmid_hold", 1, 6, 4'b0101);
    push("rmid_edge", 7, 4'b1010, 4'b1010, 4'b0101);
    push("rmid_after", 8, 4'b1010, 4'b0, 4'b0);
    run(8);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain: got %0d pending want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_glitch_filter.md
Name: multi_glitch_filter

Overview:
- Parametrised multi-channel successor to the single-bit shift-register glitch filter.
- Each channel has a synchroniser, then a saturating stability counter with a run-time programmable length.
- Outputs are the filtered level plus one-cycle rise/fall pulses per channel.
- Sits between raw asynchronous board inputs (PERST#, button, presence/strap lines) and PCIe scan control logic.

Parameters:
- NUM_CH, 4: number of independent channels.
- CNT_W, 8: stability counter width; maximum filter length is 2^CNT_W-1 cycles.
- SYNC_STAGES, 2: synchroniser flop depth per channel, minimum 2.
- RST_VAL, {NUM_CH{1'b0}}: per-channel reset value of out, sync chain and internal state.

Ports:
- clk  input  1  single clock; all logic on posedge.
- restn  input  1  synchronous active-low reset.
- filt_len  input  CNT_W  number of consecutive stable cycles required to change state; shared by all channels; quasi-static.
- in  input  NUM_CH  raw asynchronous inputs.
- out  output  NUM_CH  filtered levels, registered.
- rise  output  NUM_CH  one-cycle pulse, asserted in the same cycle out goes 0->1.
- fall  output  NUM_CH  one-cycle pulse, asserted in the same cycle out goes 1->0.

Behaviour:
- One clock, clk; reset is synchronous and active-low on restn.
- Reset, while restn=0 at a posedge:
  - sync chain[i] <= RST_VAL[i]; out <= RST_VAL; cnt[i] <= 0.
  - rise, fall <= 0; optional status is cleared.
- Sync: chain of SYNC_STAGES flops per channel; s[i] = last stage. No other logic reads in directly.
- Effective length: len_eff = (filt_len==0) ? 1 : filt_len.
- Per-channel counter update, each cycle, in priority order:
  - s==out: cnt <= 0. If cnt!=0 before this cycle, it is a rejected glitch.
  - s!=out and cnt >= len_eff-1: out <= s, cnt <= 0, and the rise or fall pulse asserts for exactly this cycle.
  - s!=out otherwise: cnt <= cnt+1. No overflow is possible, because the compare above bounds cnt at len_eff-1.
- Latency: a clean edge on in, sampled at posedge N, appears on out after posedge N+SYNC_STAGES+len_eff-1. That is SYNC_STAGES+len_eff clocks counting the sampling edge.
- Minimum pulse: a pulse stable for at least len_eff synchronised cycles always propagates. Shorter pulses never change out.
- filt_len changes mid-count: the >= compare applies the new value immediately. Lowering it below cnt+1 causes a transition on the next cycle. No counter reset occurs.
- Channels are fully independent; simultaneous transitions on all channels are legal.
- rise and fall are never both high on the same channel.
- Reset mid-count: all state returns to reset values. After release, a full len_eff count is required again.

Optional Feature:
- Macro: MULTI_GLITCH_FILTER_STATUS_EN.
- Defined:
  - Adds port glitch_clr (input, NUM_CH) and port glitch_sticky (output, NUM_CH, reset 0).
  - glitch_sticky[i] sets on a rejected glitch (s returns to out while cnt!=0).
  - glitch_sticky[i] clears when glitch_clr[i]=1.
  - If set and clear occur in the same cycle, set wins.
- Undefined: ports absent, no extra flops, behaviour otherwise identical.

Test Plan:
- Bench setup: NUM_CH=4, CNT_W=8, SYNC_STAGES=2, RST_VAL=4'b0101.
- Reset: hold restn=0 for 3 cycles with in=4'b1010 -> out=4'b0101, rise=fall=0. After release with in held, each channel toggles exactly SYNC_STAGES+filt_len clocks later with the correct rise/fall pulses (filt_len=5 -> 7 clocks).
- Latency: filt_len=5, in[0] 0->1 sampled at edge 10 -> out[0] rises after edge 16, rise[0] high for only that cycle, fall never asserted.
- Glitch rejection: filt_len=5, in[0] high for 4 cycles then low -> out[0] stays 0, no pulses. With the macro, glitch_sticky[0]=1 until glitch_clr[0] is pulsed; a same-cycle glitch plus clear leaves it 1.
- Boundary length: filt_len=5, 5-cycle high pulse passes and out[0] is high for 5 cycles. filt_len=0 behaves as 1, latency 3 clocks. filt_len=255 needs 255 stable cycles.
- Mid-operation events: reduce filt_len 200->3 while cnt=50 -> out transitions next cycle. Assert restn=0 for one cycle while cnt=3 -> out returns to RST_VAL and a full recount is required.
